// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: queues vend/change strobes and sequences motor, coin-return solenoid and inter-job gap
//   clk, reset      : clock, asynchronous active-high reset
//   vend_i          : single-cycle strobe, queue one dispense job
//   change_i        : change-owed qualifier, captured with vend_i
//   prod_sensor_i   : asynchronous product drop sensor
//   fault_clr_i     : leave FAULT, discarding the stalled job
//   motor_o         : product motor drive
//   solenoid_o      : coin-return solenoid drive
//   busy_o          : FSM not idle
//   fault_o         : motor timed out waiting for the drop sensor
//   overflow_o      : one-cycle pulse when a vend was dropped on a full queue
//   pending_o       : jobs queued but not yet started
module vend_dispense_ctrl #(
    parameter int QDEPTH         = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SOL_CYCLES     = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int CW             = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vend_i,
    input  logic          change_i,
    input  logic          prod_sensor_i,
    input  logic          fault_clr_i,
    output logic          motor_o,
    output logic          solenoid_o,
    output logic          busy_o,
    output logic          fault_o,
    output logic          overflow_o,
    output logic [CW-1:0] pending_o
);
    localparam int AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int MAXC = (TIMEOUT_CYCLES > SOL_CYCLES)
                        ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                        : ((SOL_CYCLES > GAP_CYCLES) ? SOL_CYCLES : GAP_CYCLES);
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, MOTOR, CHANGE, GAP, FAULT} state_t;

    state_t            state, next_state;
    logic [QDEPTH-1:0] q_mem;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [TW-1:0]     cnt, cnt_nxt;
    logic              chg, chg_nxt;
    logic [2:0]        sync;
    logic              empty, full, pop, push_ok, drop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(QDEPTH));
    assign pop       = (state == IDLE) && !empty;
    // a full queue still accepts a push when the head leaves in the same cycle
    assign push_ok   = vend_i && (!full || pop);
    // sync[1] is the synchronized sensor, sync[2] its previous value
    assign drop      = sync[1] && !sync[2];
    assign pending_o = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_mem      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            sync       <= '0;
        end else begin
            if (push_ok) begin
                q_mem[wr_ptr] <= change_i;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count + CW'(push_ok) - CW'(pop);
            overflow_o <= vend_i && !push_ok;
            sync       <= {sync[1:0], prod_sensor_i};
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        chg_nxt    = chg;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = MOTOR;
                    cnt_nxt    = '0;
                    chg_nxt    = q_mem[rd_ptr];
                end
            end
            MOTOR: begin
                // a drop seen on the final allowed cycle wins over the timeout
                if (drop) begin
                    next_state = chg ? CHANGE : GAP;
                    cnt_nxt    = '0;
                end else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    next_state = FAULT;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CHANGE: begin
                next_state = (cnt == TW'(SOL_CYCLES - 1)) ? GAP : CHANGE;
                cnt_nxt    = (cnt == TW'(SOL_CYCLES - 1)) ? '0 : cnt + 1'b1;
            end
            GAP: begin
                next_state = (cnt == TW'(GAP_CYCLES - 1)) ? IDLE : GAP;
                cnt_nxt    = (cnt == TW'(GAP_CYCLES - 1)) ? '0 : cnt + 1'b1;
            end
            FAULT: begin
                next_state = fault_clr_i ? IDLE : FAULT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // outputs are registered from next_state so they change together with state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            chg        <= 1'b0;
            motor_o    <= 1'b0;
            solenoid_o <= 1'b0;
            busy_o     <= 1'b0;
            fault_o    <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_nxt;
            chg        <= chg_nxt;
            motor_o    <= (next_state == MOTOR);
            solenoid_o <= (next_state == CHANGE);
            busy_o     <= (next_state != IDLE);
            fault_o    <= (next_state == FAULT);
        end
    end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: directed scoreboard bench for vend_dispense_ctrl
module tb_vend_dispense_ctrl;
    localparam int SOL = 8;

    logic       clk = 1'b0;
    logic       reset, vend_i, change_i, prod_sensor_i, fault_clr_i;
    logic       motor_o, solenoid_o, busy_o, fault_o, overflow_o;
    logic [2:0] pending_o;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  exp_q[$];
    int  mc, sc, gc;
    bit  flt;
    bit  pat[5];

    vend_dispense_ctrl dut (
        .clk(clk), .reset(reset), .vend_i(vend_i), .change_i(change_i),
        .prod_sensor_i(prod_sensor_i), .fault_clr_i(fault_clr_i),
        .motor_o(motor_o), .solenoid_o(solenoid_o), .busy_o(busy_o),
        .fault_o(fault_o), .overflow_o(overflow_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic vend_s(input bit c);
        vend_i = 1'b1;
        change_i = c;
        exp_q.push_back(c);
        tick;
        vend_i = 1'b0;
        change_i = 1'b0;
    endtask

    task automatic vend_lat(input bit c);
        vend_s(c);
        chk("lat_pending_n1", pending_o, 1);
        chk("lat_motor_n1", motor_o, 0);
        tick;
        chk("lat_motor_n2", motor_o, 1);
    endtask

    task automatic do_job(input int sj, output int m, output int s, output int g, output bit f);
        int w = 0;
        bit c = 1'b0;
        bit both = 1'b0;
        while (!motor_o && w < 30) begin
            tick;
            w++;
        end
        chk("motor_start", motor_o, 1);
        if (exp_q.size() > 0) c = exp_q.pop_front();
        chk("pending_at_start", pending_o, exp_q.size());
        m = 0;
        while (motor_o && m < 200) begin
            if (m == sj) prod_sensor_i = 1'b1;
            if (m == sj + 3) prod_sensor_i = 1'b0;
            if (solenoid_o) both = 1'b1;
            m++;
            tick;
        end
        prod_sensor_i = 1'b0;
        f = fault_o;
        s = 0;
        while (solenoid_o && s < 50) begin
            if (motor_o) both = 1'b1;
            s++;
            tick;
        end
        g = 0;
        while (busy_o && !fault_o && !motor_o && !solenoid_o && g < 50) begin
            g++;
            tick;
        end
        chk("act_exclusive", both, 0);
        if (!f) chk("sol_cycles", s, c ? SOL : 0);
    endtask

    initial begin
        reset = 1'b1;
        vend_i = 1'b0;
        change_i = 1'b0;
        prod_sensor_i = 1'b0;
        fault_clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_motor", motor_o, 0);
        chk("rst_sol", solenoid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_pending", pending_o, 0);
        reset = 1'b0;
        tick;

        // single vend without change
        vend_lat(1'b0);
        do_job(10, mc, sc, gc, flt);
        chk("t1_motor_cycles", mc, 13);
        chk("t1_gap_cycles", gc, 4);
        chk("t1_busy_end", busy_o, 0);
        chk("t1_pending_end", pending_o, 0);

        // vend with change
        vend_lat(1'b1);
        do_job(10, mc, sc, gc, flt);
        chk("t2_motor_cycles", mc, 13);
        chk("t2_gap_cycles", gc, 4);
        chk("t2_busy_end", busy_o, 0);

        // five strobes during an active job: fifth overflows
        vend_lat(1'b1);
        pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vend_i = 1'b1;
            change_i = pat[i];
            if (i < 4) exp_q.push_back(pat[i]);
            tick;
            if (i == 3) begin
                chk("t3_ovf_before", overflow_o, 0);
                chk("t3_pending_full", pending_o, 4);
            end
        end
        vend_i = 1'b0;
        change_i = 1'b0;
        chk("t3_ovf_pulse", overflow_o, 1);
        chk("t3_pending_after_drop", pending_o, 4);
        tick;
        chk("t3_ovf_one_cycle", overflow_o, 0);
        for (int j = 0; j < 5; j++) begin
            do_job(2, mc, sc, gc, flt);
            chk("t3_gap_cycles", gc, 4);
        end
        chk("t3_pending_end", pending_o, 0);

        // timeout fault with a job waiting behind it
        vend_s(1'b0);
        vend_s(1'b1);
        do_job(-1, mc, sc, gc, flt);
        chk("t4_motor_cycles", mc, 64);
        chk("t4_fault", fault_o, 1);
        repeat (5) tick;
        chk("t4_fault_held", fault_o, 1);
        chk("t4_pending_held", pending_o, 1);
        chk("t4_motor_off", motor_o, 0);
        chk("t4_busy", busy_o, 1);
        fault_clr_i = 1'b1;
        tick;
        fault_clr_i = 1'b0;
        chk("t4_fault_cleared", fault_o, 0);
        chk("t4_idle_after_clr", busy_o, 0);
        tick;
        chk("t4_next_job_motor", motor_o, 1);
        do_job(5, mc, sc, gc, flt);
        chk("t4_next_motor_cycles", mc, 8);
        chk("t4_next_fault", flt, 0);
        chk("t4_pending_end", pending_o, 0);

        // drop edge on the last allowed motor cycle completes normally
        vend_lat(1'b0);
        do_job(61, mc, sc, gc, flt);
        chk("t5_motor_cycles", mc, 64);
        chk("t5_no_fault", flt, 0);
        chk("t5_gap_cycles", gc, 4);
        // one cycle later is too late
        vend_lat(1'b0);
        do_job(62, mc, sc, gc, flt);
        chk("t5_late_motor_cycles", mc, 64);
        chk("t5_late_fault", flt, 1);
        fault_clr_i = 1'b1;
        tick;
        fault_clr_i = 1'b0;
        // sensor pulse while idle must be ignored
        prod_sensor_i = 1'b1;
        repeat (3) tick;
        prod_sensor_i = 1'b0;
        repeat (4) tick;
        chk("t5_idle_busy", busy_o, 0);
        chk("t5_idle_motor", motor_o, 0);
        vend_lat(1'b0);
        do_job(10, mc, sc, gc, flt);
        chk("t5_after_idle_pulse", mc, 13);

        // reset in the middle of the change pulse
        vend_lat(1'b1);
        prod_sensor_i = 1'b1;
        for (int k = 0; k < 20 && !solenoid_o; k++) tick;
        prod_sensor_i = 1'b0;
        chk("t6_sol_on", solenoid_o, 1);
        vend_s(1'b0);
        repeat (2) tick;
        chk("t6_sol_mid", solenoid_o, 1);
        chk("t6_pending_before", pending_o, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_sol", solenoid_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_pending", pending_o, 0);
        chk("t6_rst_motor", motor_o, 0);
        exp_q.delete();
        tick;
        reset = 1'b0;
        tick;
        vend_lat(1'b0);
        do_job(4, mc, sc, gc, flt);
        chk("t6_motor_cycles", mc, 7);
        chk("t6_gap_cycles", gc, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Consumer side of the vending FSM's delivery interface. It accepts single-cycle product-deliver (vend) and ₹5-return (change) strobes and queues them as dispense jobs. For each job it drives the product motor until the drop sensor confirms delivery, then pulses the coin-return solenoid if change is owed. Sits between the vending FSM outputs and the physical actuators; it owns timeouts and fault reporting.

Parameters:
QDEPTH, 4, dispense-job queue depth (power of 2, >=2)
TIMEOUT_CYCLES, 64, max motor-on cycles awaiting drop sensor before fault
SOL_CYCLES, 8, coin-return solenoid pulse length in cycles
GAP_CYCLES, 4, mandatory all-off cycles between jobs
CW, $clog2(QDEPTH+1), width of pending count (derived)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
vend_i  in  1  single-cycle strobe: deliver one product
change_i  in  1  qualifier: ₹5 return owed with this vend; sampled only when vend_i=1
prod_sensor_i  in  1  asynchronous drop sensor, high while product falls
fault_clr_i  in  1  clears FAULT state, discards stalled job
motor_o  out  1  product motor drive
solenoid_o  out  1  coin-return solenoid drive
busy_o  out  1  high when FSM not in IDLE
fault_o  out  1  high while in FAULT
overflow_o  out  1  single-cycle pulse: vend_i dropped, queue full
pending_o  out  CW  jobs queued, not yet started

Behaviour:
- Reset (async): all outputs 0, queue emptied, FSM=IDLE, counters 0, sensor synchronizer flops 0. Reset mid-job aborts immediately; actuators drop the same instant.
- Queue: vend_i=1 pushes entry {change_i} at clock edge. change_i with vend_i=0 ignored. Push when full (pending_o==QDEPTH) with no simultaneous pop: entry dropped, overflow_o=1 next cycle for one cycle. Push+pop same cycle allowed at any occupancy (including full); count unchanged. Pushes accepted in every state, including FAULT.
- Sensor: prod_sensor_i through 2-FF synchronizer; drop event = synced high and previous synced low (rising edge). Drop events outside MOTOR ignored.
- FSM states: IDLE, MOTOR, CHANGE, GAP, FAULT.
- IDLE: if queue non-empty, pop head, latch change bit, clear counter -> MOTOR. Empty queue: stay.
- MOTOR: motor_o=1. Drop event -> CHANGE if change bit set, else GAP. No drop by the cycle motor_o has been high TIMEOUT_CYCLES cycles -> FAULT. Drop on final cycle beats timeout.
- CHANGE: solenoid_o=1 for exactly SOL_CYCLES cycles -> GAP.
- GAP: all actuators 0 for exactly GAP_CYCLES cycles -> IDLE.
- FAULT: actuators 0, fault_o=1, queue held. fault_clr_i=1 -> IDLE; stalled job discarded, queued jobs resume. fault_clr_i in other states ignored.
- motor_o and solenoid_o never high together. Both registered outputs.
- Latency: vend_i at cycle N with IDLE and empty queue -> pending_o=1 at N+1 -> motor_o=1 from N+2.
- busy_o = (state != IDLE), registered with state.
- Counters saturate-free; widths sized for max(TIMEOUT_CYCLES, SOL_CYCLES, GAP_CYCLES).

Test Plan:
1. Single vend, change_i=0; sensor pulse 10 cycles after motor_o rises -> motor_o high ~13 cycles (sync delay), solenoid_o never high, GAP 4 cycles, busy_o falls, pending_o 1->0.
2. vend_i with change_i=1; sensor ok -> motor_o falls, solenoid_o high exactly 8 cycles, then 4 idle cycles, then IDLE.
3. Five back-to-back vend_i strobes during active job (QDEPTH=4): four queued, fifth -> overflow_o one-cycle pulse; all four jobs then dispense in order with change bits preserved.
4. No sensor pulse -> motor_o high exactly 64 cycles, then fault_o=1; queued job waits; fault_clr_i pulse -> next job starts, stalled job not retried.
5. Sensor rising edge on 64th motor cycle -> completes normally, no fault. Sensor pulse during GAP/IDLE -> ignored.
6. reset asserted mid-CHANGE -> solenoid_o, busy_o, pending_o 0 immediately; after release vend_i works normally with 2-cycle motor latency.
